// File: rtl/song_reader_pkg.sv
// Shared definitions for the song sequencer: the song_rom entry layout
// and the sequencer state encoding.
package song_reader_pkg;

    // Entry layout: [15] adv, [14:9] note, [8:3] dur, [2:0] meta
    localparam int ADV_BIT  = 15;
    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;
    localparam int META_MSB = 2;
    localparam int META_LSB = 0;

    // A note entry carrying this note number is an empty slot
    localparam logic [5:0] NOTE_REST = 6'd0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        ISSUE  = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/song_reader_if.sv
// Note event handshake between the song reader (master) and the
// downstream note player (slave).
interface song_reader_if #(
    parameter int DUR_BITS = 6
) ();

    logic                note_valid;
    logic                note_ready;
    logic [5:0]          note;
    logic [DUR_BITS-1:0] duration;
    logic [2:0]          meta;

    modport master (
        output note_valid,
        output note,
        output duration,
        output meta,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  note,
        input  duration,
        input  meta,
        output note_ready
    );

endinterface

// File: rtl/song_reader_beat_down_counter.sv
// Beat tick down-counter used for time-advance entries. Loaded with the
// entry duration, decremented on each enabled beat, flags the last tick.
module beat_down_counter #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              en,
    output logic              terminal
);

    localparam logic [DATA_W-1:0] CNT_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_cnt;

    // Load has priority; decrement stops at zero so a stray enable cannot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    // The beat that arrives while the count is 1 is the final one
    assign terminal = (r_cnt == CNT_ONE);

endmodule

// File: rtl/song_reader.sv
// Song sequencer: walks one 32-entry song region of song_rom, issues note
// events over a valid/ready handshake and stalls on time-advance entries
// for a counted number of beat ticks. Pulses song_done at the end.
module song_reader
    import song_reader_pkg::*;
#(
    parameter int SONG_BITS = 2,
    parameter int IDX_BITS  = 5,
    parameter int DUR_BITS  = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    input  logic                          beat,
    output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
    input  logic [15:0]                   rom_dout,
    song_reader_if.master                 nb,
    output logic                          song_done,
    output logic                          busy
);

    localparam logic [IDX_BITS-1:0] IDX_ONE  = {{(IDX_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_BITS-1:0] IDX_LAST = {IDX_BITS{1'b1}};

    state_t                        r_state;
    logic                          r_play_q;
    logic [SONG_BITS-1:0]          r_song_l;
    logic [IDX_BITS-1:0]           r_idx;
    logic [SONG_BITS+IDX_BITS-1:0] r_rom_addr;
    logic                          r_note_valid;
    logic [5:0]                    r_note;
    logic [DUR_BITS-1:0]           r_dur;
    logic [2:0]                    r_meta;
    logic                          r_song_done;
    logic                          r_busy;

    logic                          w_adv;
    logic [5:0]                    w_note;
    logic [DUR_BITS-1:0]           w_dur;
    logic [2:0]                    w_meta;
    logic                          w_abort;
    logic                          w_run;
    logic                          w_advance;
    logic                          w_last;
    logic [IDX_BITS-1:0]           w_idx_nxt;
    logic                          w_cnt_load;
    logic                          w_cnt_en;
    logic                          w_cnt_term;

    // Entry fields straight off the ROM data; only meaningful in DECODE
    assign w_adv  = rom_dout[ADV_BIT];
    assign w_note = rom_dout[NOTE_MSB:NOTE_LSB];
    assign w_dur  = rom_dout[DUR_MSB:DUR_LSB];
    assign w_meta = rom_dout[META_MSB:META_LSB];

    // A new song selection while running restarts the walk and overrides
    // any handshake or beat in the same cycle
    assign w_abort = (r_state != IDLE) && play && (song != r_song_l);
    assign w_run   = play && !w_abort;

    // Conditions that move on to the next entry (empty slot, accepted
    // note, or final beat of a wait)
    assign w_advance = w_run && (
        ((r_state == DECODE) && !w_adv && (w_note == NOTE_REST)) ||
        ((r_state == ISSUE)  && nb.note_ready) ||
        ((r_state == WAIT)   && beat && w_cnt_term));

    assign w_last    = (r_idx == IDX_LAST);
    assign w_idx_nxt = r_idx + IDX_ONE;

    assign w_cnt_load = w_run && (r_state == DECODE) && w_adv && (w_dur != '0);
    assign w_cnt_en   = w_run && (r_state == WAIT) && beat;

    beat_down_counter #(
        .DATA_W (DUR_BITS)
    ) u_beat_cnt (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (w_cnt_load),
        .load_val (w_dur),
        .en       (w_cnt_en),
        .terminal (w_cnt_term)
    );

    // Sequencer FSM; all outputs are registered here. Pause (play=0) holds
    // every active state because each transition below is gated by play.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_play_q     <= 1'b0;
            r_song_l     <= '0;
            r_idx        <= '0;
            r_rom_addr   <= '0;
            r_note_valid <= 1'b0;
            r_note       <= '0;
            r_dur        <= '0;
            r_meta       <= '0;
            r_song_done  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_play_q    <= play;
            r_song_done <= 1'b0;
            if (w_abort) begin
                r_song_l     <= song;
                r_idx        <= '0;
                r_rom_addr   <= {song, {IDX_BITS{1'b0}}};
                r_note_valid <= 1'b0;
                r_state      <= FETCH;
            end else if (w_advance) begin
                r_note_valid <= 1'b0;
                if (w_last) begin
                    // Never wrap into the next song's region
                    r_state     <= DONE;
                    r_song_done <= 1'b1;
                end else begin
                    r_idx      <= w_idx_nxt;
                    r_rom_addr <= {r_song_l, w_idx_nxt};
                    r_state    <= FETCH;
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (play && !r_play_q) begin
                            r_song_l   <= song;
                            r_idx      <= '0;
                            r_rom_addr <= {song, {IDX_BITS{1'b0}}};
                            r_busy     <= 1'b1;
                            r_state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (play) begin
                            r_state <= DECODE;
                        end
                    end
                    DECODE: begin
                        if (play) begin
                            if (!w_adv) begin
                                r_note       <= w_note;
                                r_dur        <= w_dur;
                                r_meta       <= w_meta;
                                r_note_valid <= 1'b1;
                                r_state      <= ISSUE;
                            end else if (w_dur != '0) begin
                                r_state <= WAIT;
                            end else begin
                                r_state     <= DONE;
                                r_song_done <= 1'b1;
                            end
                        end
                    end
                    ISSUE, WAIT: begin
                        // Left only through advance or abort
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr      = r_rom_addr;
    assign nb.note_valid = r_note_valid;
    assign nb.note       = r_note;
    assign nb.duration   = r_dur;
    assign nb.meta       = r_meta;
    assign song_done     = r_song_done;
    assign busy          = r_busy;

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Sequencer that walks one song region of song_rom and feeds the note player stage directly downstream.
- Each fetched 16-bit entry is either a note event or a time-advance event.
- Note events go out on a valid/ready handshake. Time-advance events stall the walk for a counted number of beat ticks.
- Ends on a terminator entry or at the end of the song region, then reports song_done.

Parameters:
- SONG_BITS, 2, selects 1 of 4 songs; upper bits of rom_addr.
- IDX_BITS, 5, entries per song = 32; lower bits of rom_addr.
- DUR_BITS, 6, duration field width (beat ticks).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- play  in  1  level: 1 = run, 0 = pause
- song  in  SONG_BITS  song select
- beat  in  1  one-cycle tick, 1/48 of a quarter note
- rom_addr  out  SONG_BITS+IDX_BITS  registered address to song_rom
- rom_dout  in  16  song_rom data; registered, 1-cycle latency
- note_valid  out  1  note event valid
- note_ready  in  1  note player accepts
- note  out  6  note number
- duration  out  DUR_BITS  note length in beat ticks
- meta  out  3  entry bits [2:0], passed through
- song_done  out  1  one-cycle pulse at end of song
- busy  out  1  high in every state except IDLE

Behaviour:
- Entry format: [15] adv, [14:9] note, [8:3] dur, [2:0] meta.
- Reset (async, reset_n=0) forces:
  - state IDLE, idx 0, rom_addr 0
  - note_valid, note, duration, meta, song_done, busy all 0
  - beat counter 0, play_q 0
- play_q is play registered one cycle; it is used for rising-edge detection.
- Address: rom_addr = {song_l, idx}. It is updated only on entry to FETCH. song_l is the song value latched at start.
- State IDLE:
  - On play & ~play_q (rising edge): song_l <= song, idx <= 0, go to FETCH.
  - A sustained-high play with no rising edge does not start a song.
- State FETCH (exactly 1 cycle): song_rom registers rom_addr; go to DECODE.
- State DECODE: rom_dout is valid in this cycle.
  - adv=0 and note!=0: latch note, duration, meta; go to ISSUE.
  - adv=0 and note==0: empty slot; ADVANCE.
  - adv=1 and dur!=0: load cnt = dur; go to WAIT.
  - adv=1 and dur==0: terminator; go to DONE.
- State ISSUE:
  - note_valid = 1. note, duration and meta stay stable until the handshake.
  - On note_valid & note_ready: drop note_valid next cycle; ADVANCE.
- State WAIT:
  - Each beat pulse decrements cnt.
  - beat with cnt==1: ADVANCE. Total wait is exactly dur beat pulses.
- ADVANCE:
  - idx==31: go to DONE. idx does not wrap into the next song.
  - Otherwise: idx+1, go to FETCH.
- State DONE: song_done = 1 for one cycle; go to IDLE.
- Pause (play=0 in FETCH, DECODE, ISSUE, WAIT): all state is held.
  - beat is ignored; cnt is frozen.
  - note_valid stays asserted if already high, but a handshake is not accepted while paused.
  - play returning to 1 resumes in the same cycle.
- Song change (song != song_l while busy and play=1) aborts the current song:
  - note_valid drops; this is the only allowed valid drop without a handshake.
  - song_l <= song, idx <= 0, go to FETCH.
  - Song change takes priority over a same-cycle handshake or beat.
- Signals outside their consuming state are ignored: beat outside WAIT, note_ready outside ISSUE.
- Asynchronous reset mid-song returns to IDLE immediately. No song_done is generated.

Decomposition:
- song_pkg holds:
  - entry field positions: ADV_BIT=15, NOTE_MSB/LSB=14/9, DUR_MSB/LSB=8/3, META_MSB/LSB=2/0
  - state encoding: IDLE, FETCH, DECODE, ISSUE, WAIT, DONE
  - NOTE_REST=0
- One sub-module, beat_down_counter: load, enable on beat, terminal flag.
- Everything else stays in song_reader.

Test Plan:
- Start and first note: song=0, play rises; entry0 = {0,28,48,0}, note_ready tied 1.
  -> rom_addr=0; note_valid high 3 cycles after the edge with note=28, duration=48; rom_addr=1 next.
- Wait timing: entry = {1,0,48,0}, beat every 4 cycles.
  -> next FETCH only after the 48th beat pulse; rom_addr does not change before it.
- Backpressure: note_ready held 0 for 10 cycles.
  -> note_valid, note and duration stable all 10 cycles; advance happens one cycle after note_ready=1.
- Terminator: entry 5 of song 1 = {1,x,0,0}.
  -> song_done pulse 1 cycle, busy=0, rom_addr holds 37; play held high does not restart.
- End of region: song 3 with no terminator.
  -> after idx 31 (rom_addr=127), song_done pulses; rom_addr never wraps to 0 mid-song.
- Abort and pause: change song 0->2 while in WAIT.
  -> next rom_addr=64, cnt discarded.
  Pause mid-ISSUE.
  -> note_valid held, no advance.
  reset_n low mid-song.
  -> all outputs 0 immediately.
